pipe_ctrl_unit: RTL and testbench

Pipelined control unit for the 5-stage RISC-V core: it generates the datapath control signals and pipelines them through the stages. It decodes the IF/ID opcode into the stage control bundles and carries them through ID/EX, EX/MEM and MEM/WB control registers. It also owns hazard control: load-use interlock, branch flush, an external bubble request, and a parametrised multi-cycle data-memory wait. It replaces the combinational decoder plus external control registers. The datapath keeps operands, immediates and rd; this block keeps only control bits and its own rd/rs tracking for hazards.

---
 rtl/pipe_ctrl_unit.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control for the 5-stage RISC-V core: ID decode, ID/EX -> EX/MEM -> MEM/WB
// control registers, and hazard handling (load-use, branch flush, bubble, memory wait).
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 0,
    parameter int HAZARD_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  bubble_req,
    input  logic                  zero_mem,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  pc_src,
    output logic                  ex_alu_src,
    output logic [1:0]            ex_alu_op,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_branch,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic                  mem_wait
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

    // Nested so each stage register keeps exactly the bits its later stages consume.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic     mem_read;
        logic     mem_write;
        logic     branch;
        wb_ctrl_t wb;
    } m_ctrl_t;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        m_ctrl_t    m;
    } ctrl_t;

    ctrl_t                 dec_ctrl;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  hazard;
    logic                  freeze;

    ctrl_t                 idex_ctrl_d,  idex_ctrl_q;
    logic [REG_ADDR_W-1:0] idex_rd_d,    idex_rd_q;
    m_ctrl_t               exmem_ctrl_d, exmem_ctrl_q;
    wb_ctrl_t              memwb_ctrl_d, memwb_ctrl_q;
    logic [CNT_W-1:0]      wait_cnt_d,   wait_cnt_q;

    // Bundle layout matches {alu_src, alu_op, mem_read, mem_write, branch, reg_write, mem_to_reg}.
    always_comb begin
        dec_ctrl = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode_id)
            OP_R:      begin dec_ctrl = ctrl_t'(8'b0_10_000_10); uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_I:      begin dec_ctrl = ctrl_t'(8'b1_10_000_10); uses_rs1 = 1'b1; end
            OP_LOAD:   begin dec_ctrl = ctrl_t'(8'b1_00_100_11); uses_rs1 = 1'b1; end
            OP_STORE:  begin dec_ctrl = ctrl_t'(8'b1_00_010_00); uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_BRANCH: begin dec_ctrl = ctrl_t'(8'b0_01_001_00); uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            default:   dec_ctrl = '0;
        endcase
    end

    assign hazard = (HAZARD_EN != 0) && idex_ctrl_q.m.mem_read && (idex_rd_q != '0) &&
                    ((uses_rs1 && (rs1_id == idex_rd_q)) || (uses_rs2 && (rs2_id == idex_rd_q)));

    assign freeze = (MEM_LAT != 0) && (exmem_ctrl_q.mem_read || exmem_ctrl_q.mem_write) &&
                    (wait_cnt_q != LAT_C);

    assign pc_src = exmem_ctrl_q.branch & zero_mem;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        mem_wait     = 1'b0;
        idex_ctrl_d  = dec_ctrl;
        idex_rd_d    = rd_id;
        exmem_ctrl_d = idex_ctrl_q.m;
        memwb_ctrl_d = exmem_ctrl_q.wb;
        wait_cnt_d   = '0;

        if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            mem_wait     = 1'b1;
            idex_ctrl_d  = idex_ctrl_q;
            idex_rd_d    = idex_rd_q;
            exmem_ctrl_d = exmem_ctrl_q;
            memwb_ctrl_d = '0;
            wait_cnt_d   = wait_cnt_q + 1'b1;
        end else if (pc_src) begin
            ifid_flush   = 1'b1;
            idex_ctrl_d  = '0;
            idex_rd_d    = '0;
            exmem_ctrl_d = '0;
        end else if (hazard) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_ctrl_d  = '0;
            idex_rd_d    = '0;
        end else if (bubble_req) begin
            idex_ctrl_d  = '0;
            idex_rd_d    = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments; reset empties every stage and abandons any wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ctrl_q  <= '0;
            idex_rd_q    <= '0;
            exmem_ctrl_q <= '0;
            memwb_ctrl_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            idex_ctrl_q  <= idex_ctrl_d;
            idex_rd_q    <= idex_rd_d;
            exmem_ctrl_q <= exmem_ctrl_d;
            memwb_ctrl_q <= memwb_ctrl_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign ex_alu_src    = idex_ctrl_q.alu_src;
    assign ex_alu_op     = idex_ctrl_q.alu_op;
    assign mem_read      = exmem_ctrl_q.mem_read;
    assign mem_write     = exmem_ctrl_q.mem_write;
    assign mem_branch    = exmem_ctrl_q.branch;
    assign wb_reg_write  = memwb_ctrl_q.reg_write;
    assign wb_mem_to_reg = memwb_ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: default, MEM_LAT=3 and HAZARD_EN=0 instances share
// the same ID-stage stimulus; each scenario checks the instance it concerns.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_NOP    = 7'b0000000;

    typedef struct packed {
        logic       pc_write;
        logic       ifid_write;
        logic       ifid_flush;
        logic       pc_src;
        logic       ex_alu_src;
        logic [1:0] ex_alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_branch;
        logic       wb_reg_write;
        logic       wb_mem_to_reg;
        logic       mem_wait;
    } outs_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode_id;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic       bubble_req;
    logic       zero_mem;

    outs_t o0;  // defaults
    outs_t ol;  // MEM_LAT = 3
    outs_t on;  // HAZARD_EN = 0

    int n_cmp;
    int n_err;
    int cnt_wait, cnt_wr, cnt_wb;

    pipe_ctrl_unit u_dut0 (
        .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .bubble_req(bubble_req), .zero_mem(zero_mem),
        .pc_write(o0.pc_write), .ifid_write(o0.ifid_write), .ifid_flush(o0.ifid_flush),
        .pc_src(o0.pc_src), .ex_alu_src(o0.ex_alu_src), .ex_alu_op(o0.ex_alu_op),
        .mem_read(o0.mem_read), .mem_write(o0.mem_write), .mem_branch(o0.mem_branch),
        .wb_reg_write(o0.wb_reg_write), .wb_mem_to_reg(o0.wb_mem_to_reg), .mem_wait(o0.mem_wait)
    );

    pipe_ctrl_unit #(.MEM_LAT(3)) u_dut_lat (
        .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .bubble_req(bubble_req), .zero_mem(zero_mem),
        .pc_write(ol.pc_write), .ifid_write(ol.ifid_write), .ifid_flush(ol.ifid_flush),
        .pc_src(ol.pc_src), .ex_alu_src(ol.ex_alu_src), .ex_alu_op(ol.ex_alu_op),
        .mem_read(ol.mem_read), .mem_write(ol.mem_write), .mem_branch(ol.mem_branch),
        .wb_reg_write(ol.wb_reg_write), .wb_mem_to_reg(ol.wb_mem_to_reg), .mem_wait(ol.mem_wait)
    );

    pipe_ctrl_unit #(.HAZARD_EN(0)) u_dut_nh (
        .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .bubble_req(bubble_req), .zero_mem(zero_mem),
        .pc_write(on.pc_write), .ifid_write(on.ifid_write), .ifid_flush(on.ifid_flush),
        .pc_src(on.pc_src), .ex_alu_src(on.ex_alu_src), .ex_alu_op(on.ex_alu_op),
        .mem_read(on.mem_read), .mem_write(on.mem_write), .mem_branch(on.mem_branch),
        .wb_reg_write(on.wb_reg_write), .wb_mem_to_reg(on.wb_mem_to_reg), .mem_wait(on.mem_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd);
        opcode_id = op;
        rs1_id    = rs1;
        rs2_id    = rs2;
        rd_id     = rd;
    endtask

    task automatic drain(input int n);
        set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
        bubble_req = 1'b0;
        zero_mem   = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bubble_req = 1'b0;
        zero_mem   = 1'b0;
        set_id(OP_NOP, 5'd0, 5'd0, 5'd0);

        // Reset state
        #1;
        check("rst_pc_write",   o0.pc_write,   1);
        check("rst_ifid_write", o0.ifid_write, 1);
        check("rst_ifid_flush", o0.ifid_flush, 0);
        check("rst_pc_src",     o0.pc_src,     0);
        check("rst_mem_wait",   ol.mem_wait,   0);
        check("rst_stages",     {o0.ex_alu_src, o0.ex_alu_op, o0.mem_read, o0.mem_write,
                                 o0.mem_branch, o0.wb_reg_write, o0.wb_mem_to_reg}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // R-type latency through the stages
        set_id(OP_R, 5'd1, 5'd2, 5'd3);
        tick();
        check("r_ex_alu_op",  o0.ex_alu_op,  2'b10);
        check("r_ex_alu_src", o0.ex_alu_src, 0);
        check("r_pc_write0",  o0.pc_write,   1);
        set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
        tick();
        check("r_mem_read",   o0.mem_read,   0);
        check("r_pc_write1",  o0.pc_write,   1);
        tick();
        check("r_wb_reg_write",  o0.wb_reg_write,  1);
        check("r_wb_mem_to_reg", o0.wb_mem_to_reg, 0);
        drain(2);

        // Load x5 then add x6,x5,x1
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd5);
        tick();
        check("ld_ex_alu_src", o0.ex_alu_src, 1);
        set_id(OP_R, 5'd5, 5'd1, 5'd6);
        #1;
        check("lu_pc_write",     o0.pc_write,   0);
        check("lu_ifid_write",   o0.ifid_write, 0);
        check("lu_nh_pc_write",  on.pc_write,   1);
        tick();
        check("lu_bubble_ex",    {o0.ex_alu_src, o0.ex_alu_op}, 0);
        check("lu_load_in_mem",  o0.mem_read,   1);
        check("lu_one_cycle",    o0.pc_write,   1);
        check("lu_nh_add_in_ex", on.ex_alu_op,  2'b10);
        tick();
        check("lu_add_in_ex",    o0.ex_alu_op,  2'b10);
        check("lu_bubble_mem",   o0.mem_read,   0);
        drain(6);

        // Load writing x0: no stall
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd0);
        tick();
        set_id(OP_R, 5'd0, 5'd0, 5'd6);
        #1;
        check("lu_x0_pc_write", o0.pc_write, 1);
        drain(6);

        // rs2 is used by branch, not by I-type
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd11);
        tick();
        set_id(OP_BRANCH, 5'd0, 5'd11, 5'd0);
        #1;
        check("lu_rs2_branch", o0.pc_write, 0);
        set_id(OP_I, 5'd1, 5'd11, 5'd12);
        #1;
        check("lu_rs2_itype", o0.pc_write, 1);
        drain(6);

        // Branch in MEM while a load-use hazard sits in ID
        set_id(OP_BRANCH, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd7);
        tick();
        check("br_mem_branch", o0.mem_branch, 1);
        set_id(OP_R, 5'd7, 5'd1, 5'd8);
        zero_mem = 1'b0;
        #1;
        check("br_nz_pc_src",   o0.pc_src,   0);
        check("br_nz_pc_write", o0.pc_write, 0);
        zero_mem = 1'b1;
        #1;
        check("br_pc_src",     o0.pc_src,     1);
        check("br_ifid_flush", o0.ifid_flush, 1);
        check("br_pc_write",   o0.pc_write,   1);
        check("br_ifid_write", o0.ifid_write, 1);
        tick();
        zero_mem = 1'b0;
        check("br_flushed_ex",  {o0.ex_alu_src, o0.ex_alu_op}, 0);
        check("br_flushed_mem", {o0.mem_read, o0.mem_write, o0.mem_branch}, 0);
        drain(6);

        // Unknown opcode and bubble_req on a valid load
        set_id(7'b1111111, 5'd1, 5'd2, 5'd3);
        tick();
        check("unk_ex", {o0.ex_alu_src, o0.ex_alu_op}, 0);
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd8);
        bubble_req = 1'b1;
        #1;
        check("bub_pc_write",   o0.pc_write,   1);
        check("bub_ifid_write", o0.ifid_write, 1);
        tick();
        bubble_req = 1'b0;
        set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
        check("bub_ex",       {o0.ex_alu_src, o0.ex_alu_op}, 0);
        check("unk_mem",      {o0.mem_read, o0.mem_write, o0.mem_branch}, 0);
        tick();
        check("bub_mem_read", o0.mem_read, 0);
        check("unk_wb",       o0.wb_reg_write, 0);
        check("no_x_dut0",    ((^o0) === 1'bx) ? 1 : 0, 0);
        check("no_x_lat",     ((^ol) === 1'bx) ? 1 : 0, 0);
        drain(4);

        // MEM_LAT=3 store followed by an R-type
        set_id(OP_STORE, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(OP_R, 5'd1, 5'd2, 5'd9);
        cnt_wait = 0;
        cnt_wr   = 0;
        cnt_wb   = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
            if (ol.mem_wait) begin
                check("lat_wait_pc_write", ol.pc_write,     0);
                check("lat_wait_wb",       ol.wb_reg_write, 0);
            end
            if (i == 2) check("lat_ex_held", ol.ex_alu_op, 2'b10);
            cnt_wait += int'(ol.mem_wait);
            cnt_wr   += int'(ol.mem_write);
            cnt_wb   += int'(ol.wb_reg_write);
        end
        check("lat_wait_cycles",  cnt_wait, 3);
        check("lat_write_cycles", cnt_wr,   4);
        check("lat_r_reaches_wb", cnt_wb,   1);
        drain(2);

        // Reset pulsed during a MEM_LAT=3 wait
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd10);
        tick();
        set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        check("rstw_in_wait", ol.mem_wait, 1);
        rst_n = 1'b0;
        #1;
        check("rstw_mem_read", ol.mem_read,   0);
        check("rstw_mem_wait", ol.mem_wait,   0);
        check("rstw_pc_write", ol.pc_write,   1);
        check("rstw_stages",   {ol.ex_alu_src, ol.ex_alu_op, ol.mem_read, ol.mem_write,
                                ol.mem_branch, ol.wb_reg_write, ol.wb_mem_to_reg}, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("rstw_post_wait",     ol.mem_wait, 0);
        check("rstw_post_pc_write", ol.pc_write, 1);
        check("rstw_post_mem_read", ol.mem_read, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
